// File: rtl/l4_out_ser.sv
// Layer-4 output stage: captures the 64 neuron results from the 16-lane bus,
// streams them one per beat under valid/ready, and reports the frame argmax.
module l4_out_ser #(
    parameter int unsigned DW    = 18,
    parameter int unsigned LANES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [LANES-1:0][DW-1:0] din,
    output logic                     tx_done,
    output logic [DW-1:0]            out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_last,
    output logic [5:0]               max_idx,
    output logic [DW-1:0]            max_val,
    output logic                     max_vld
);
    localparam int unsigned N     = LANES * WORDS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned W_W   = $clog2(WORDS);
    localparam int unsigned L_W   = $clog2(LANES);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CAP,
        S_STREAM,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [W_W-1:0]     w_q, w_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rdy_q;
    logic [DW-1:0]      cand_val_q, cand_val_d;
    logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
    logic [DW-1:0]      mem [N];

    logic               accept;
    logic               beat_gt;
    logic               out_vld_d;
    logic               out_last_d;
    logic [DW-1:0]      out_data_d;
    logic               tx_done_d;
    logic               max_vld_d;

    // Next-state, counters, running argmax and next output values
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        idx_d      = idx_q;
        cand_val_d = cand_val_q;
        cand_idx_d = cand_idx_q;
        accept     = out_vld && out_rdy;
        beat_gt    = $signed(out_data) > $signed(cand_val_q);

        unique case (state_q)
            S_INIT: begin
                state_d = rdy ? S_FLUSH : S_IDLE;
            end
            S_IDLE: begin
                if (rdy && !rdy_q) begin
                    state_d = S_CAP;
                    w_d     = '0;
                end
            end
            S_CAP: begin
                w_d = w_q + W_W'(1);
                if (w_q == W_W'(WORDS - 1)) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    // strict compare so ties keep the lowest index
                    if (idx_q == '0 || beat_gt) begin
                        cand_val_d = out_data;
                        cand_idx_d = idx_q;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE, S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        out_vld_d  = (state_d == S_STREAM);
        out_data_d = out_vld_d ? mem[idx_d] : '0;
        out_last_d = out_vld_d && (idx_d == IDX_W'(N - 1));
        tx_done_d  = (state_d == S_DONE) || (state_d == S_FLUSH);
        max_vld_d  = (state_d == S_DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            w_q        <= '0;
            idx_q      <= '0;
            rdy_q      <= 1'b0;
            cand_val_q <= '0;
            cand_idx_q <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            tx_done    <= 1'b0;
            max_vld    <= 1'b0;
            max_idx    <= '0;
            max_val    <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            idx_q      <= idx_d;
            rdy_q      <= rdy;
            cand_val_q <= cand_val_d;
            cand_idx_q <= cand_idx_d;
            out_vld    <= out_vld_d;
            out_data   <= out_data_d;
            out_last   <= out_last_d;
            tx_done    <= tx_done_d;
            max_vld    <= max_vld_d;
            // load on entry to DONE so the result is visible with max_vld
            if (state_d == S_DONE) begin
                max_idx <= 6'(cand_idx_d);
                max_val <= cand_val_d;
            end
        end
    end

    // Frame buffer, intentionally not reset
    always_ff @(posedge clk) begin
        if (state_q == S_CAP) begin
            for (int l = 0; l < LANES; l++) begin
                mem[{w_q, L_W'(l)}] <= din[l];
            end
        end
    end

endmodule
